mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 44 ++++
 rtl/mem_access_ctrl_lane.sv | 35 +++
 rtl/mem_access_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store access controller.
// Holds the op encodings, the FSM state enum and the lane-width constants.
// Also holds small helpers for the alignment check and load/store classification.
package mem_access_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Word accesses need both low address bits clear.
  // Half accesses need only bit 0 clear.
  // Byte accesses are always aligned.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         is_misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: is_misaligned = a[0];
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input op_e op);
    is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// lane_extend: selects a little-endian byte/half lane of a word and extends it.
// Ports: word_i (memory word), addr_lo_i (byte offset), op_i (access op) -> result_o.
// Purely combinational; LB/LH sign-extend, LBU/LHU zero-extend, anything else passes the word.
module lane_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        addr_lo_i,
  input  op_e               op_i,
  output logic [WORD_W-1:0] result_o
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (op_i)
      OP_LB:   result_o = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      OP_LBU:  result_o = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
      OP_LH:   result_o = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      OP_LHU:  result_o = {{(WORD_W-HALF_W){1'b0}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request load/store controller in front of a synchronous RAM.
// Ports: clk/reset, request (start, op, addr, wdata), status (busy, done, misaligned, rdata),
//        RAM side (mem_addr, mem_wr, mem_wdata, mem_rdata). Sub-word stores use read-modify-write.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [WORD_W-1:0] addr_q;
  // Holds the store data from acceptance; for SH/SB it is overwritten with the merged word.
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              mis_q;

  logic              accept;
  op_e               op_in;
  logic [WORD_W-1:0] load_ext;
  logic [WORD_W-1:0] merged;

  assign op_in  = op_e'(op);
  assign accept = (state_q == ST_IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_misaligned(op_in, addr[1:0])) state_d = ST_DONE;
          else if (op_in == OP_SW)             state_d = ST_WRITE;
          else                                 state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_CAPT;
      ST_CAPT:  state_d = is_store(op_q) ? ST_WRITE : ST_DONE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    mem_wr     = (state_q == ST_WRITE);
    misaligned = (state_q == ST_DONE) && mis_q;
  end

  lane_extend u_lane (
    .word_i    (mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .op_i      (op_q),
    .result_o  (load_ext)
  );

  // Store merge: only the addressed lane takes new data, the rest comes from the read word.
  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Request and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= addr;
        wdata_q <= wdata;
        mis_q   <= is_misaligned(op_in, addr[1:0]);
      end
      // RAM data is valid during CAPT, one cycle after the address went out in READ.
      if (state_q == ST_CAPT) begin
        if (is_store(op_q)) wdata_q <= merged;
        else                rdata_q <= load_ext;
      end
    end
  end

  assign rdata     = rdata_q;
  assign mem_addr  = {addr_q[WORD_W-1:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule
